// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_pkg
// Purpose  : Shared types and constants for the SRAM-to-AXI3 bridge:
//            bridge FSM state encoding, core access-size codes and the fixed
//            AXI burst fields used for single-beat transfers.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } bridge_state_t;

  // Core-side access sizes; numerically equal to AXI AxSIZE for 1/2/4 bytes.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam int         AXI_LEN_SINGLE = 0;

  // Core size code to AXI AxSIZE.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_sram_bridge_if.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_bridge_if
// Purpose  : AXI3 single-master bus bundle (AR/R/AW/W/B channels).
// Ports    : master modport - drives AR/AW/W payload+valid, rready, bready
//            slave  modport - drives arready, R channel, awready, wready, B
// Revision : 1.0 - initial release
// ============================================================================
interface axi_sram_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // AR channel
  logic [3:0]          arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic [1:0]          arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  // R channel
  logic [3:0]          rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;
  // AW channel
  logic [3:0]          awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [3:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic [1:0]          awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  // W channel
  logic [3:0]          wid;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  // B channel
  logic [3:0]          bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface
`default_nettype wire

// File: rtl/axi_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_sram_bridge
// Purpose  : Single-outstanding bridge from the core SRAM-like port to AXI3.
//            Each accepted request becomes one single-beat AXI read or write;
//            completion is a one-cycle mem_ready pulse, load data registered.
//            flush suppresses the completion report of the access in flight
//            while the AXI transaction itself always runs to the end.
// Ports    : aclk, aresetn (sync, active-low)
//            mem_a/mem_access/mem_write/mem_size/mem_sel/mem_st_data - request
//            mem_ready/mem_data - completion pulse and registered load data
//            flush - cancel report of current/pending access
//            axi   - AXI3 master modport
// Revision : 1.0 - initial release
// ============================================================================
module axi_sram_bridge
  import axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'b0000,
  parameter int         ADDR_W = 32,
  parameter int         DATA_W = 32
) (
  input  wire logic                aclk,
  input  wire logic                aresetn,
  input  wire logic [ADDR_W-1:0]   mem_a,
  input  wire logic                mem_access,
  input  wire logic                mem_write,
  input  wire logic [1:0]          mem_size,
  input  wire logic [DATA_W/8-1:0] mem_sel,
  input  wire logic [DATA_W-1:0]   mem_st_data,
  output logic                     mem_ready,
  output logic [DATA_W-1:0]        mem_data,
  input  wire logic                flush,
  axi_sram_bridge_if.master        axi
);

  bridge_state_t       r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic [1:0]          r_size;
  logic [DATA_W/8-1:0] r_sel;
  logic [DATA_W-1:0]   r_data;
  logic                r_aw_done;
  logic                r_w_done;
  logic                r_drop;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_awvalid;
  logic                r_wvalid;
  logic                r_bready;
  logic                r_mem_ready;
  logic [DATA_W-1:0]   r_mem_data;

  logic w_aw_fire;
  logic w_w_fire;
  logic w_aw_now;
  logic w_w_now;
  logic w_drop_now;

  assign w_aw_fire  = r_awvalid & axi.awready;
  assign w_w_fire   = r_wvalid & axi.wready;
  // Channel counts as done if it handshook earlier or is handshaking now.
  assign w_aw_now   = r_aw_done | w_aw_fire;
  assign w_w_now    = r_w_done | w_w_fire;
  // A flush in the completing cycle must already suppress the report.
  assign w_drop_now = r_drop | flush;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_size      <= '0;
      r_sel       <= '0;
      r_data      <= '0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_drop      <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_mem_ready <= 1'b0;
      r_mem_data  <= '0;
    end else begin
      r_mem_ready <= 1'b0;
      if (flush && (r_state != ST_IDLE)) begin
        r_drop <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          if (mem_access && !flush) begin
            r_addr  <= mem_a;
            r_write <= mem_write;
            r_size  <= mem_size;
            r_sel   <= mem_sel;
            r_data  <= mem_st_data;
            if (mem_write) begin
              r_state   <= ST_WR;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
            end else begin
              r_state   <= ST_RD_ADDR;
              r_arvalid <= 1'b1;
            end
          end
        end

        ST_RD_ADDR: begin
          if (axi.arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end

        ST_RD_DATA: begin
          if (axi.rvalid) begin
            r_rready    <= 1'b0;
            r_state     <= ST_DONE;
            r_mem_ready <= ~w_drop_now;
            if (!w_drop_now) begin
              r_mem_data <= axi.rdata;
            end
          end
        end

        ST_WR: begin
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_now && w_w_now) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (axi.bvalid) begin
            r_bready    <= 1'b0;
            r_state     <= ST_DONE;
            r_mem_ready <= ~w_drop_now;
          end
        end

        ST_DONE: begin
          // Last assignment wins: entering IDLE always clears drop.
          r_drop  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_ready   = r_mem_ready;
  assign mem_data    = r_mem_data;

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = r_addr;
  assign axi.arlen   = 8'(AXI_LEN_SINGLE);
  assign axi.arsize  = axi_size(r_size);
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = 2'b00;
  assign axi.arcache = 4'b0000;
  assign axi.arprot  = 3'b000;
  assign axi.arvalid = r_arvalid;
  assign axi.rready  = r_rready;

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = r_addr;
  assign axi.awlen   = 4'(AXI_LEN_SINGLE);
  assign axi.awsize  = axi_size(r_size);
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = 2'b00;
  assign axi.awcache = 4'b0000;
  assign axi.awprot  = 3'b000;
  assign axi.awvalid = r_awvalid;

  assign axi.wid     = AXI_ID;
  assign axi.wdata   = r_data;
  assign axi.wstrb   = r_sel;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = r_wvalid;
  assign axi.bready  = r_bready;

  // Response IDs/status are not used by the core; r_write is kept for debug.
  logic w_unused_ok;
  assign w_unused_ok = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp, r_write};

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_sram_bridge
// Purpose  : Self-checking bench for axi_sram_bridge with a delay-programmable
//            AXI slave, channel hold monitor and mem_data scoreboard.
// Ports    : none (top-level bench)
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_sram_bridge;
  import axi_pkg::*;

  logic        aclk;
  logic        aresetn;
  logic [31:0] mem_a;
  logic        mem_access;
  logic        mem_write;
  logic [1:0]  mem_size;
  logic [3:0]  mem_sel;
  logic [31:0] mem_st_data;
  logic        mem_ready;
  logic [31:0] mem_data;
  logic        flush;

  axi_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) axi_bus ();

  axi_sram_bridge #(.AXI_ID(4'b0000), .ADDR_W(32), .DATA_W(32)) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .mem_a       (mem_a),
    .mem_access  (mem_access),
    .mem_write   (mem_write),
    .mem_size    (mem_size),
    .mem_sel     (mem_sel),
    .mem_st_data (mem_st_data),
    .mem_ready   (mem_ready),
    .mem_data    (mem_data),
    .flush       (flush),
    .axi         (axi_bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Slave configuration and bookkeeping
  int          ar_dly = 0, r_dly = 0, aw_dly = 0, w_dly = 0, b_dly = 0;
  logic [31:0] slv_rdata = 32'h0;
  int          ready_cnt = 0;
  int          r_hs_cnt = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_md = 32'h0;

  // AXI slave + monitors, all evaluated at the falling edge.
  initial begin : slave
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    logic rd_pend, r_fired, aw_got, w_got, b_fired;
    logic p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [31:0] p_araddr, p_awaddr, p_wdata;
    axi_bus.arready = 0; axi_bus.awready = 0; axi_bus.wready = 0;
    axi_bus.rvalid = 0; axi_bus.rdata = 0; axi_bus.rid = 0; axi_bus.rresp = 0; axi_bus.rlast = 1;
    axi_bus.bvalid = 0; axi_bus.bid = 0; axi_bus.bresp = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        rd_pend = 0; r_fired = 0; aw_got = 0; w_got = 0; b_fired = 0;
        p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
        p_araddr = 0; p_awaddr = 0; p_wdata = 0;
        axi_bus.arready = 0; axi_bus.awready = 0; axi_bus.wready = 0;
        axi_bus.rvalid = 0; axi_bus.bvalid = 0;
      end else begin
        // A valid not yet accepted must hold with stable payload.
        if (p_arv && !p_arr) begin
          chk("arvalid_hold", 32'(axi_bus.arvalid), 32'd1);
          chk("araddr_hold", axi_bus.araddr, p_araddr);
        end
        if (p_awv && !p_awr) begin
          chk("awvalid_hold", 32'(axi_bus.awvalid), 32'd1);
          chk("awaddr_hold", axi_bus.awaddr, p_awaddr);
        end
        if (p_wv && !p_wr) begin
          chk("wvalid_hold", 32'(axi_bus.wvalid), 32'd1);
          chk("wdata_hold", axi_bus.wdata, p_wdata);
        end
        if (mem_ready) begin
          ready_cnt++;
          if (sb_q.size() == 0) chk("unexpected_ready", 32'd1, 32'd0);
          else chk("mem_data", mem_data, sb_q.pop_front());
        end
        // R channel (before AR so rvalid never precedes the AR handshake)
        if (r_fired) begin axi_bus.rvalid = 0; r_fired = 0; end
        if (rd_pend) begin
          if (r_cnt >= r_dly) begin axi_bus.rvalid = 1; axi_bus.rdata = slv_rdata; end
          else r_cnt++;
          if (axi_bus.rvalid && axi_bus.rready) begin r_fired = 1; rd_pend = 0; r_hs_cnt++; end
        end
        // AR channel
        if (axi_bus.arvalid) begin
          if (ar_cnt >= ar_dly) axi_bus.arready = 1;
          else begin axi_bus.arready = 0; ar_cnt++; end
        end else axi_bus.arready = 0;
        if (axi_bus.arvalid && axi_bus.arready) begin ar_cnt = 0; rd_pend = 1; r_cnt = 0; end
        // B channel
        if (b_fired) begin axi_bus.bvalid = 0; b_fired = 0; end
        if (aw_got && w_got) begin
          if (b_cnt >= b_dly) axi_bus.bvalid = 1;
          else b_cnt++;
          if (axi_bus.bvalid && axi_bus.bready) begin b_fired = 1; aw_got = 0; w_got = 0; b_cnt = 0; end
        end
        // AW / W channels
        if (axi_bus.awvalid) begin
          if (aw_cnt >= aw_dly) axi_bus.awready = 1;
          else begin axi_bus.awready = 0; aw_cnt++; end
        end else axi_bus.awready = 0;
        if (axi_bus.awvalid && axi_bus.awready) begin aw_got = 1; aw_cnt = 0; end
        if (axi_bus.wvalid) begin
          if (w_cnt >= w_dly) axi_bus.wready = 1;
          else begin axi_bus.wready = 0; w_cnt++; end
        end else axi_bus.wready = 0;
        if (axi_bus.wvalid && axi_bus.wready) begin w_got = 1; w_cnt = 0; end
        p_arv = axi_bus.arvalid; p_arr = axi_bus.arready; p_araddr = axi_bus.araddr;
        p_awv = axi_bus.awvalid; p_awr = axi_bus.awready; p_awaddr = axi_bus.awaddr;
        p_wv  = axi_bus.wvalid;  p_wr  = axi_bus.wready;  p_wdata  = axi_bus.wdata;
      end
    end
  end

  // Drive a request at a falling edge; returns at the next falling edge
  // (cycle 1) with the request inputs scrambled.
  task automatic start_req(input logic wr, input logic [31:0] a, input logic [1:0] sz,
                           input logic [3:0] sel, input logic [31:0] d, input logic report);
    mem_access = 1; mem_write = wr; mem_a = a; mem_size = sz; mem_sel = sel; mem_st_data = d;
    if (report) begin
      if (!wr) exp_md = slv_rdata;
      sb_q.push_back(exp_md);
    end
    @(negedge aclk);
    mem_access = 0; mem_write = ~wr; mem_a = ~a; mem_size = 2'd3; mem_sel = ~sel; mem_st_data = ~d;
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit seen;
    start = ready_cnt;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge aclk);
      if (ready_cnt != start) seen = 1;
    end
    if (!seen) chk("timeout_mem_ready", 32'd0, 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, 32'(axi_bus.arvalid), 32'd0);
    chk({tag, "_awvalid"}, 32'(axi_bus.awvalid), 32'd0);
    chk({tag, "_wvalid"},  32'(axi_bus.wvalid),  32'd0);
    chk({tag, "_rready"},  32'(axi_bus.rready),  32'd0);
    chk({tag, "_bready"},  32'(axi_bus.bready),  32'd0);
    chk({tag, "_mem_ready"}, 32'(mem_ready), 32'd0);
  endtask

  initial begin : main
    int base;
    int hs_base;
    aresetn = 0; mem_access = 0; mem_write = 0; mem_a = 0; mem_size = 0;
    mem_sel = 0; mem_st_data = 0; flush = 0;
    repeat (3) @(negedge aclk);
    check_idle_outputs("reset");
    chk("reset_mem_data", mem_data, 32'h0);
    aresetn = 1;
    @(negedge aclk);

    // T1: zero-wait word read
    slv_rdata = 32'hDEADBEEF;
    start_req(1'b0, 32'h1FC00000, SZ_WORD, 4'hF, 32'h0, 1'b1);
    chk("t1_c1_arvalid", 32'(axi_bus.arvalid), 32'd1);
    chk("t1_araddr", axi_bus.araddr, 32'h1FC00000);
    chk("t1_arsize", 32'(axi_bus.arsize), 32'd2);
    chk("t1_arlen", 32'(axi_bus.arlen), 32'd0);
    chk("t1_arburst", 32'(axi_bus.arburst), 32'd1);
    chk("t1_arid", 32'(axi_bus.arid), 32'd0);
    @(negedge aclk);
    chk("t1_c2_rready", 32'(axi_bus.rready), 32'd1);
    chk("t1_c2_arvalid", 32'(axi_bus.arvalid), 32'd0);
    @(negedge aclk);
    chk("t1_c3_mem_ready", 32'(mem_ready), 32'd1);
    @(negedge aclk);
    chk("t1_c4_mem_ready", 32'(mem_ready), 32'd0);
    chk("t1_mem_data_held", mem_data, 32'hDEADBEEF);

    // T2: delayed slave, single pulse
    ar_dly = 3; r_dly = 2; slv_rdata = 32'h0BADF00D;
    base = ready_cnt;
    start_req(1'b0, 32'h1FC00010, SZ_WORD, 4'hF, 32'h0, 1'b1);
    wait_done(30);
    repeat (3) @(negedge aclk);
    chk("t2_pulse_count", 32'(ready_cnt - base), 32'd1);
    ar_dly = 0; r_dly = 0;

    // T3: byte write, W accepted two cycles after AW
    w_dly = 2;
    start_req(1'b1, 32'h1FAF0000, SZ_BYTE, 4'b0100, 32'h00AB0000, 1'b1);
    chk("t3_c1_awvalid", 32'(axi_bus.awvalid), 32'd1);
    chk("t3_c1_wvalid", 32'(axi_bus.wvalid), 32'd1);
    chk("t3_awaddr", axi_bus.awaddr, 32'h1FAF0000);
    chk("t3_awsize", 32'(axi_bus.awsize), 32'd0);
    chk("t3_awlen", 32'(axi_bus.awlen), 32'd0);
    chk("t3_wstrb", 32'(axi_bus.wstrb), 32'h4);
    chk("t3_wdata", axi_bus.wdata, 32'h00AB0000);
    chk("t3_wlast", 32'(axi_bus.wlast), 32'd1);
    @(negedge aclk);
    chk("t3_c2_awvalid", 32'(axi_bus.awvalid), 32'd0);
    chk("t3_c2_wvalid", 32'(axi_bus.wvalid), 32'd1);
    @(negedge aclk);
    chk("t3_c3_wvalid", 32'(axi_bus.wvalid), 32'd1);
    chk("t3_c3_bready", 32'(axi_bus.bready), 32'd0);
    @(negedge aclk);
    chk("t3_c4_wvalid", 32'(axi_bus.wvalid), 32'd0);
    chk("t3_c4_bready", 32'(axi_bus.bready), 32'd1);
    wait_done(20);
    w_dly = 0;
    @(negedge aclk);

    // T4: flush during RD_DATA
    r_dly = 3; slv_rdata = 32'h12345678;
    base = ready_cnt; hs_base = r_hs_cnt;
    start_req(1'b0, 32'h00001000, SZ_WORD, 4'hF, 32'h0, 1'b0);
    @(negedge aclk);
    chk("t4_rready", 32'(axi_bus.rready), 32'd1);
    flush = 1;
    @(negedge aclk);
    flush = 0;
    repeat (8) @(negedge aclk);
    chk("t4_no_ready", 32'(ready_cnt - base), 32'd0);
    chk("t4_r_handshake", 32'(r_hs_cnt - hs_base), 32'd1);
    chk("t4_mem_data_kept", mem_data, exp_md);
    r_dly = 0;

    // T5: access with flush in IDLE is ignored
    mem_access = 1; mem_write = 0; mem_a = 32'h2000; flush = 1;
    repeat (3) begin
      @(negedge aclk);
      chk("t5_arvalid", 32'(axi_bus.arvalid), 32'd0);
      chk("t5_awvalid", 32'(axi_bus.awvalid), 32'd0);
    end
    mem_write = 1;
    @(negedge aclk);
    chk("t5_wr_awvalid", 32'(axi_bus.awvalid), 32'd0);
    mem_access = 0; flush = 0;
    @(negedge aclk);

    // T6: reset mid-write with awvalid pending
    aw_dly = 5;
    start_req(1'b1, 32'h3000, SZ_WORD, 4'hF, 32'hA5A5A5A5, 1'b1);
    @(negedge aclk);
    chk("t6_awvalid_before", 32'(axi_bus.awvalid), 32'd1);
    aresetn = 0;
    sb_q.delete();
    exp_md = 32'h0;
    @(negedge aclk);
    check_idle_outputs("t6");
    chk("t6_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("t6_mem_data", mem_data, 32'h0);
    aw_dly = 0;
    aresetn = 1;
    @(negedge aclk);

    // T7: half read after reset, inputs scrambled after acceptance
    slv_rdata = 32'hCAFEF00D;
    start_req(1'b0, 32'h00000102, SZ_HALF, 4'h3, 32'h0, 1'b1);
    chk("t7_araddr", axi_bus.araddr, 32'h00000102);
    chk("t7_arsize", 32'(axi_bus.arsize), 32'd1);
    wait_done(20);
    @(negedge aclk);

    // T8: zero-wait write keeps load data
    start_req(1'b1, 32'h00000200, SZ_WORD, 4'hF, 32'h11223344, 1'b1);
    wait_done(20);
    @(negedge aclk);
    chk("t8_mem_data_kept", mem_data, 32'hCAFEF00D);

    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/axi_sram_bridge.md
Name: axi_sram_bridge

Overview:
Single-outstanding bridge from the core's unified SRAM-like memory port to an AXI3 master interface. It sits directly downstream of the instruction/data request mux in the CPU top. It converts each accepted request into one single-beat AXI read (AR/R) or write (AW/W/B) transaction. It returns a one-cycle mem_ready pulse, with read data held in a register. A flush input suppresses the completion report for a cancelled access; the AXI handshake itself is never abandoned.

Parameters:
AXI_ID, 4'b0000, value driven on arid/awid/wid
ADDR_W, 32, address width
DATA_W, 32, data width (wstrb width = DATA_W/8)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
mem_a  in  32  byte address of request
mem_access  in  1  request valid (level)
mem_write  in  1  1=store, 0=load/fetch
mem_size  in  2  0=byte, 1=half, 2=word
mem_sel  in  4  byte strobes for store
mem_st_data  in  32  store data
mem_ready  out  1  one-cycle completion pulse
mem_data  out  32  registered load data
flush  in  1  cancel current or pending access
arid/araddr/arlen[7:0]/arsize/arburst/arlock/arcache/arprot/arvalid  out  AXI AR channel
arready  in  1
rid[3:0]/rdata[31:0]/rresp[1:0]/rlast/rvalid  in  AXI R channel
rready  out  1
awid/awaddr/awlen[3:0]/awsize/awburst/awlock/awcache/awprot/awvalid  out  AXI AW channel
awready  in  1
wid/wdata/wstrb/wlast/wvalid  out  AXI W channel
wready  in  1
bid[3:0]/bresp[1:0]/bvalid  in  AXI B channel
bready  out  1

Behaviour:
- Fixed fields:
  - arlen=0, awlen=0; arburst=awburst=2'b01; lock, cache and prot all 0.
  - wlast=1; arid=awid=wid=AXI_ID.
  - arsize=awsize={1'b0,req_size}.
  - rid, rresp, rlast, bid and bresp are ignored.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE:
  - If mem_access=1 and flush=0, latch addr, write, size, sel and st_data into request registers.
  - Go to RD_ADDR if write=0, otherwise to WR.
  - If flush=1, no request is accepted.
- RD_ADDR: arvalid=1, araddr=req_addr. On arvalid&arready go to RD_DATA.
- RD_DATA:
  - rready=1.
  - On rvalid, capture rdata into mem_data and go to DONE.
- WR:
  - awvalid=~aw_done and wvalid=~w_done; awaddr=req_addr, wdata=req_data, wstrb=req_sel.
  - aw_done and w_done are set independently on their own handshakes, in either order or the same cycle.
  - When both are done (counting a handshake in the current cycle), go to WR_RESP and clear both flags.
- WR_RESP: bready=1. On bvalid go to DONE.
- DONE:
  - mem_ready = ~drop for exactly one cycle, then IDLE.
  - No new request is accepted in DONE.
- drop flag:
  - Set when flush=1 in any state other than IDLE.
  - Cleared on entry to IDLE.
  - A dropped read leaves mem_data unchanged.
- Valid signals are registered outputs and never drop before their handshake completes (AXI rule).
- mem_data holds its value until the next non-dropped read completes.
- Latency with a zero-wait slave:
  - Read: request sampled at cycle 0, arvalid at cycle 1, rready at cycle 2, mem_ready at cycle 3.
  - Write: request at cycle 0, aw/w at cycle 1, bready at cycle 2, mem_ready at cycle 3.
- Request inputs may change after acceptance; only the latched copies are used.
- Reset, including mid-transaction:
  - State goes to IDLE; all valid/ready outputs and mem_ready go to 0.
  - mem_data=0; request registers, aw_done, w_done and drop are cleared.

Decomposition:
- Shared package axi_pkg holds:
  - FSM state typedef.
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - Constants BURST_INCR=2'b01 and AXI_LEN_SINGLE=0.
- No sub-module. The single FSM, request registers and done flags stay in one block.

Test Plan:
- Read 0x1FC00000, arready at cycle 1, rvalid with rdata=0xDEADBEEF at cycle 2 -> mem_ready=1 at cycle 3, mem_data=0xDEADBEEF, arsize=2.
- Read with arready delayed 3 cycles and rvalid delayed 2 -> araddr and arvalid held stable throughout, exactly one mem_ready pulse.
- Write 0x1FAF0000, size 0, sel=4'b0100, data 0x00AB0000, awready at cycle 1, wready at cycle 3 -> awvalid drops after cycle 1, wvalid held to cycle 3, wstrb=0100, then bready, then mem_ready.
- flush asserted during RD_DATA -> transaction completes on AXI, mem_ready stays 0, mem_data keeps its old value.
- mem_access=1 with flush=1 in IDLE -> arvalid and awvalid remain 0.
- aresetn=0 during WR with awvalid=1 -> next cycle all valids 0, state IDLE, mem_ready 0.
